// File: rtl/clock_pkg.sv
// clock_pkg: shared set-mode state encoding, blink-group codes and helpers.
// Revision 1.0
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } set_state_t;

  localparam logic [1:0] BLINK_NONE = 2'd0;
  localparam logic [1:0] BLINK_HOUR = 2'd1;
  localparam logic [1:0] BLINK_MIN  = 2'd2;
  localparam logic [1:0] BLINK_SEC  = 2'd3;

  function automatic set_state_t next_set_state(input set_state_t s);
    set_state_t n;
    case (s)
      RUN:      n = SET_HOUR;
      SET_HOUR: n = SET_MIN;
      SET_MIN:  n = SET_SEC;
      default:  n = RUN;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] blink_of(input set_state_t s);
    logic [1:0] b;
    case (s)
      SET_HOUR: b = BLINK_HOUR;
      SET_MIN:  b = BLINK_MIN;
      SET_SEC:  b = BLINK_SEC;
      default:  b = BLINK_NONE;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/repeat_timer.sv
// repeat_timer: hold-then-repeat tick generator for a held increment button.
// Revision 1.0
`default_nettype none

module repeat_timer #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES < 1) ? 1 : $clog2(REPEAT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_LIM  = RW'(REPEAT_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = '1;
  localparam logic [RW-1:0] REP_MAX  = '1;

  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          rpt_q, rpt_d;

  // rpt_q marks the repeat phase: hold delay has elapsed, now pacing by rep_q.
  always_comb begin
    hold_d = hold_q;
    rep_d  = rep_q;
    rpt_d  = rpt_q;
    tick   = 1'b0;
    if (clr) begin
      hold_d = '0;
      rep_d  = '0;
      rpt_d  = 1'b0;
    end else if (run) begin
      if (!rpt_q) begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        if (hold_d >= HOLD_LIM) begin
          tick  = 1'b1;
          rpt_d = 1'b1;
          rep_d = '0;
        end
      end else begin
        rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + RW'(1);
        if (rep_d >= REP_LIM) begin
          tick  = 1'b1;
          rep_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      rep_q  <= '0;
      rpt_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
      rpt_q  <= rpt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl: clock time-setting FSM with auto-repeat and inactivity timeout.
// Revision 1.0
`default_nettype none

module set_mode_ctrl
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES  = 5_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  input  logic       inc_level,
  output logic       hour_inc,
  output logic       min_inc,
  output logic       sec_clr,
  output logic       set_active,
  output logic [1:0] blink_sel
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = '1;

  set_state_t    state_q, state_d;
  logic [TW-1:0] to_q, to_d;
  logic          hour_inc_q, hour_inc_d;
  logic          min_inc_q, min_inc_d;
  logic          sec_clr_q, sec_clr_d;
  logic          set_active_q, set_active_d;
  logic [1:0]    blink_sel_q, blink_sel_d;

  logic          in_set, in_hm, rpt_clr, rpt_run, rpt_tick;
  logic          timeout_hit, bump;
  logic [TW-1:0] to_inc;

  assign in_set  = (state_q != RUN);
  assign in_hm   = (state_q == SET_HOUR) || (state_q == SET_MIN);
  assign rpt_run = inc_level && in_hm;
  assign rpt_clr = mode_pulse || inc_pulse || !rpt_run;

  repeat_timer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_repeat_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rpt_clr),
    .run   (rpt_run),
    .tick  (rpt_tick)
  );

  // Any button activity counts as presence; a simultaneous mode press still lets a timeout win.
  always_comb begin
    to_inc      = (to_q == TO_MAX) ? to_q : to_q + TW'(1);
    timeout_hit = in_set && !inc_pulse && !inc_level && (to_inc >= TO_LIM);

    state_d = state_q;
    if (mode_pulse) begin
      state_d = timeout_hit ? RUN : next_set_state(state_q);
    end else if (timeout_hit) begin
      state_d = RUN;
    end

    to_d = (!in_set || mode_pulse || inc_pulse || inc_level || timeout_hit) ? '0 : to_inc;

    bump         = in_set && !mode_pulse && !timeout_hit && (inc_pulse || rpt_tick);
    hour_inc_d   = bump && (state_q == SET_HOUR);
    min_inc_d    = bump && (state_q == SET_MIN);
    sec_clr_d    = bump && (state_q == SET_SEC);
    set_active_d = (state_d != RUN);
    blink_sel_d  = blink_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      to_q         <= '0;
      hour_inc_q   <= 1'b0;
      min_inc_q    <= 1'b0;
      sec_clr_q    <= 1'b0;
      set_active_q <= 1'b0;
      blink_sel_q  <= BLINK_NONE;
    end else begin
      state_q      <= state_d;
      to_q         <= to_d;
      hour_inc_q   <= hour_inc_d;
      min_inc_q    <= min_inc_d;
      sec_clr_q    <= sec_clr_d;
      set_active_q <= set_active_d;
      blink_sel_q  <= blink_sel_d;
    end
  end

  assign hour_inc   = hour_inc_q;
  assign min_inc    = min_inc_q;
  assign sec_clr    = sec_clr_q;
  assign set_active = set_active_q;
  assign blink_sel  = blink_sel_q;

endmodule

`default_nettype wire
